// File: rtl/random_delay_timer.sv
// random_delay_timer
// Reaction-time game timer. An accepted start latches a clamped random delay
// (500..3500 ms), waits that long, then lights go_led and measures how many
// milliseconds pass before the player presses the button. A press before
// go_led is a false start; no press within MAX_REACTION_MS is a timeout.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   start        single-cycle round request (honoured in IDLE/RESULT only)
//   btn          debounced, clk-synchronous button level (1 = pressed)
//   delay_ms     random delay in ms, sampled on an accepted start
//   go_led       high while the player is expected to react
//   busy         high while a round is running (WAIT or ARMED)
//   done         one-cycle pulse when a round ends
//   false_start  sticky: round ended with a press before go_led
//   timeout      sticky: round ended with no press in time
//   reaction_ms  measured reaction time, held until the next accepted start
module random_delay_timer #(
  parameter int CYCLES_PER_MS   = 100000,
  parameter int MAX_REACTION_MS = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        btn,
  input  logic [11:0] delay_ms,
  output logic        go_led,
  output logic        busy,
  output logic        done,
  output logic        false_start,
  output logic        timeout,
  output logic [13:0] reaction_ms
);

  localparam int                 PRESC_W    = $clog2(CYCLES_PER_MS);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CYCLES_PER_MS - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
  localparam logic [PRESC_W-1:0] PRESC_ZERO = PRESC_W'(0);
  localparam logic [13:0]        MAX_MS     = 14'(MAX_REACTION_MS);
  localparam logic [11:0]        DELAY_MIN  = 12'd500;
  localparam logic [11:0]        DELAY_MAX  = 12'd3500;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ARMED  = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  // Limit the random delay to the playable window.
  function automatic logic [11:0] clamp_delay(input logic [11:0] d);
    logic [11:0] r;
    if (d < DELAY_MIN) begin
      r = DELAY_MIN;
    end else if (d > DELAY_MAX) begin
      r = DELAY_MAX;
    end else begin
      r = d;
    end
    return r;
  endfunction

  state_t               state_r, state_n;
  logic [PRESC_W-1:0]   presc_r, presc_n;
  logic [13:0]          ms_r, ms_n;
  logic [11:0]          delay_r, delay_n;
  logic                 btn_q_r;
  logic                 go_r, go_n;
  logic                 done_r, done_n;
  logic                 fs_r, fs_n;
  logic                 to_r, to_n;
  logic [13:0]          rms_r, rms_n;
  logic                 tick_s;
  logic                 press_s;
  logic [13:0]          ms_inc_s;

  assign tick_s   = (presc_r == PRESC_LAST);
  // Only a rising edge counts, so a button held through start is ignored.
  assign press_s  = btn & ~btn_q_r;
  assign ms_inc_s = ms_r + 14'd1;

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      presc_r <= PRESC_ZERO;
      ms_r    <= 14'd0;
      delay_r <= DELAY_MIN;
      btn_q_r <= 1'b0;
      go_r    <= 1'b0;
      done_r  <= 1'b0;
      fs_r    <= 1'b0;
      to_r    <= 1'b0;
      rms_r   <= 14'd0;
    end else begin
      state_r <= state_n;
      presc_r <= presc_n;
      ms_r    <= ms_n;
      delay_r <= delay_n;
      btn_q_r <= btn;
      go_r    <= go_n;
      done_r  <= done_n;
      fs_r    <= fs_n;
      to_r    <= to_n;
      rms_r   <= rms_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n = state_r;
    presc_n = tick_s ? PRESC_ZERO : (presc_r + PRESC_ONE);
    ms_n    = ms_r;
    delay_n = delay_r;
    go_n    = go_r;
    done_n  = 1'b0;
    fs_n    = fs_r;
    to_n    = to_r;
    rms_n   = rms_r;

    case (state_r)
      S_IDLE, S_RESULT: begin
        // Prescaler parks at zero between rounds.
        presc_n = PRESC_ZERO;
        if (start) begin
          state_n = S_WAIT;
          delay_n = clamp_delay(delay_ms);
          ms_n    = 14'd0;
          go_n    = 1'b0;
          fs_n    = 1'b0;
          to_n    = 1'b0;
          rms_n   = 14'd0;
        end else begin
          state_n = state_r;
        end
      end

      S_WAIT: begin
        // A press wins even on the cycle the delay expires.
        if (press_s) begin
          state_n = S_RESULT;
          presc_n = PRESC_ZERO;
          fs_n    = 1'b1;
          rms_n   = 14'd0;
          go_n    = 1'b0;
          done_n  = 1'b1;
        end else if (tick_s) begin
          if (ms_inc_s == {2'b00, delay_r}) begin
            state_n = S_ARMED;
            presc_n = PRESC_ZERO;
            ms_n    = 14'd0;
            go_n    = 1'b1;
          end else begin
            ms_n = ms_inc_s;
          end
        end else begin
          ms_n = ms_r;
        end
      end

      S_ARMED: begin
        // The reaction time is the count before any same-cycle tick.
        if (press_s) begin
          state_n = S_RESULT;
          presc_n = PRESC_ZERO;
          rms_n   = ms_r;
          go_n    = 1'b0;
          done_n  = 1'b1;
        end else if (tick_s) begin
          if (ms_inc_s >= MAX_MS) begin
            state_n = S_RESULT;
            presc_n = PRESC_ZERO;
            ms_n    = ms_inc_s;
            to_n    = 1'b1;
            rms_n   = MAX_MS;
            go_n    = 1'b0;
            done_n  = 1'b1;
          end else begin
            ms_n = ms_inc_s;
          end
        end else begin
          ms_n = ms_r;
        end
      end

      default: begin
        state_n = S_IDLE;
        presc_n = PRESC_ZERO;
        go_n    = 1'b0;
      end
    endcase
  end

  assign go_led      = go_r;
  assign busy        = (state_r == S_WAIT) || (state_r == S_ARMED);
  assign done        = done_r;
  assign false_start = fs_r;
  assign timeout     = to_r;
  assign reaction_ms = rms_r;

endmodule

// File: doc/random_delay_timer.md
RANDOM_DELAY_TIMER -- requirements
Module: random_delay_timer

Interface
REQ-001 Parameter CYCLES_PER_MS, default 100000, clk cycles per 1 ms tick (minimum 2).
REQ-002 Parameter MAX_REACTION_MS, default 9999, reaction timeout in ms (maximum 16383).
REQ-003 clk  input  1  system clock; all logic rising-edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  single-cycle request to begin a round.
REQ-006 btn  input  1  debounced, clk-synchronous player button level (1 = pressed).
REQ-007 delay_ms  input  12  random delay from the game's random generator, sampled only on accepted start.
REQ-008 go_led  output  1  high while the player is expected to react.
REQ-009 busy  output  1  high in WAIT and ARMED.
REQ-010 done  output  1  one-cycle pulse when a round ends, for any reason.
REQ-011 false_start  output  1  sticky flag: the round ended with a press before go_led.
REQ-012 timeout  output  1  sticky flag: the round ended with no press within MAX_REACTION_MS.
REQ-013 reaction_ms  output  14  measured reaction time, held until the next accepted start.

Function
REQ-014 FSM states: IDLE, WAIT, ARMED, RESULT.
REQ-015 start in IDLE or RESULT is accepted; start in WAIT or ARMED is ignored.
REQ-016 Accepted start: next cycle is WAIT; latch delay clamped to 500..3500 (below 500 -> 500, above 3500 -> 3500).
REQ-017 Accepted start: clear false_start, timeout and reaction_ms; clear the prescaler and ms counter.
REQ-018 Prescaler counts 0..CYCLES_PER_MS-1 and wraps; tick = prescaler at CYCLES_PER_MS-1.
REQ-019 Prescaler is reset to 0 on every entry to WAIT and to ARMED.
REQ-020 WAIT: ms counter increments on each tick.
REQ-021 WAIT: on the tick where the incremented count equals the latched delay, go to ARMED, set go_led=1 and clear the ms counter.
REQ-022 Press = rising edge of btn (btn=1 and registered prior btn=0); btn held through start is not a press.
REQ-023 Press in WAIT, including the expiry cycle of REQ-021: go to RESULT with false_start=1, reaction_ms=0, go_led=0 and done pulse.
REQ-024 ARMED: ms counter increments on each tick (14-bit, no wrap).
REQ-025 Press in ARMED: go to RESULT with reaction_ms = current ms count, go_led=0 and done pulse.
REQ-026 A tick in the same cycle as an ARMED press is not counted.
REQ-027 ARMED timeout: when the count reaches MAX_REACTION_MS with no press, go to RESULT with timeout=1, reaction_ms=MAX_REACTION_MS, go_led=0 and done pulse.
REQ-028 done is asserted in the cycle the FSM enters RESULT, for exactly 1 cycle.
REQ-029 RESULT holds all outputs until an accepted start.
REQ-030 Latency from start to go_led = clamped delay x CYCLES_PER_MS + 1 cycles.
REQ-031 busy = (state==WAIT)||(state==ARMED), decoded from registered state.

Reset
REQ-032 reset asserted forces IDLE immediately, at any time including mid-round.
REQ-033 Reset values: go_led=0, busy=0, done=0, false_start=0, timeout=0, reaction_ms=0.
REQ-034 Reset values: prescaler=0, ms counter=0, latched delay=500, registered btn=0.
REQ-035 The first clock edge after reset deassertion samples inputs normally.

Verification (CYCLES_PER_MS=4, MAX_REACTION_MS=50)
REQ-036 Normal round: delay_ms=500, start, then press 37 ticks after go_led -> go_led rises 2001 cycles after start; done pulse; reaction_ms=37; false_start=0; timeout=0.
REQ-037 False start: delay_ms=1000, press at tick 200 of WAIT -> go_led never rises; false_start=1; reaction_ms=0; done pulse.
REQ-038 Timeout: delay_ms=600, no press -> 50 ticks after go_led: timeout=1, reaction_ms=50, go_led=0.
REQ-039 Clamp and held button: delay_ms=4000 with btn held high through start -> go_led after 3500 ms (14001 cycles) and no false start; delay_ms=100 -> go_led after 500 ms.
REQ-040 Ignored start and reset mid-round: a second start during WAIT leaves timing unchanged; reset during ARMED -> all outputs 0 asynchronously; a new start then runs normally.
REQ-041 Simultaneity: press on the delay-expiry cycle -> false_start=1; press on an ARMED tick cycle -> reaction_ms excludes that tick.
